// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-byte write enables and an optional extra read pipeline register.
// Define DPRAM_CLEAR_EN to zero the whole array after every reset before accesses are accepted.
module dual_port_ram_be #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic              re_a,
  input  logic              re_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              collision,
  output logic              init_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              wr_a, wr_b, rd_a, rd_b, act_a, act_b;
  logic [DATA_W-1:0] mask_a, mask_b, old_a, old_b, rword_a, rword_b;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q, coll_q;

`ifdef DPRAM_CLEAR_EN
  typedef enum logic {StClear, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q     <= StReady;
            init_busy_q <= 1'b0;
          end
        end
        default: init_busy_q <= 1'b0;
      endcase
    end
  end

  assign busy = init_busy_q;
`else
  assign busy = 1'b0;
`endif

  assign init_busy = busy;

  assign wr_a  = we_a & ~busy;
  assign wr_b  = we_b & ~busy;
  assign rd_a  = re_a & ~busy;
  assign rd_b  = re_b & ~busy;
  assign act_a = wr_a | rd_a;
  assign act_b = wr_b | rd_b;

  always_comb begin
    mask_a = '0;
    mask_b = '0;
    for (int i = 0; i < NB; i++) begin
      mask_a[i*8 +: 8] = {8{be_a[i]}};
      mask_b[i*8 +: 8] = {8{be_b[i]}};
    end
    old_a   = mem[addr_a];
    old_b   = mem[addr_b];
    rword_a = (RDW_MODE == 0 && wr_a) ? ((old_a & ~mask_a) | (wdata_a & mask_a)) : old_a;
    rword_b = (RDW_MODE == 0 && wr_b) ? ((old_b & ~mask_b) | (wdata_b & mask_b)) : old_b;
  end

  // Port A is written last so it owns any byte both ports enable on the same word.
  always_ff @(posedge clk) begin
`ifdef DPRAM_CLEAR_EN
    if (busy) mem[cnt_q] <= '0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      if (rd_a) rdata_a_q <= rword_a;
      if (rd_b) rdata_b_q <= rword_b;
      coll_q <= act_a && act_b && (wr_a || wr_b) && (addr_a == addr_b);
    end
  end

  assign collision = coll_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rdata_a_q2, rdata_b_q2;
    logic              rvalid_a_q2, rvalid_b_q2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_a_q2  <= '0;
        rdata_b_q2  <= '0;
        rvalid_a_q2 <= 1'b0;
        rvalid_b_q2 <= 1'b0;
      end else begin
        rvalid_a_q2 <= rvalid_a_q;
        rvalid_b_q2 <= rvalid_b_q;
        if (rvalid_a_q) rdata_a_q2 <= rdata_a_q;
        if (rvalid_b_q) rdata_b_q2 <= rdata_b_q;
      end
    end

    assign rdata_a  = rdata_a_q2;
    assign rdata_b  = rdata_b_q2;
    assign rvalid_a = rvalid_a_q2;
    assign rvalid_b = rvalid_b_q2;
  end else begin : g_no_out_reg
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (latency 1 write-first, latency 2 read-first)
// share stimulus; a byte-level memory model feeds per-port expected-read queues.
module tb_dual_port_ram_be;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk, rst;
  logic [3:0]  addr_a, addr_b, be_a, be_b;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, re_a, re_b;
  logic [31:0] rd [4];
  logic        rv [4];
  logic        coll [2];
  logic        busy [2];

  exp_t        sb [4][$];
  logic [31:0] model [16];
  logic [31:0] last [4];
  logic        exp_c;
  int          tests, fails, cyc;

  dual_port_ram_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a),
    .wdata_b(wdata_b), .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b), .re_a(re_a),
    .re_b(re_b), .rdata_a(rd[0]), .rdata_b(rd[1]), .rvalid_a(rv[0]), .rvalid_b(rv[1]),
    .collision(coll[0]), .init_busy(busy[0])
  );

  dual_port_ram_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a),
    .wdata_b(wdata_b), .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b), .re_a(re_a),
    .re_b(re_b), .rdata_a(rd[2]), .rdata_b(rd[3]), .rvalid_a(rv[2]), .rvalid_b(rv[3]),
    .collision(coll[1]), .init_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    merge = o;
    for (int i = 0; i < 4; i++) if (b[i]) merge[i*8 +: 8] = n[i*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic ev;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 4; k++) begin
      ev = (sb[k].size() > 0) && (sb[k][0].due == cyc);
      chk($sformatf("rvalid[%0d]@%0d", k, cyc), {31'b0, rv[k]}, {31'b0, ev});
      if (ev) begin
        e = sb[k].pop_front();
        chk($sformatf("rdata[%0d]@%0d", k, cyc), rd[k], e.data);
        last[k] = e.data;
      end else begin
        chk($sformatf("rdata_hold[%0d]@%0d", k, cyc), rd[k], last[k]);
      end
    end
    for (int d = 0; d < 2; d++) chk($sformatf("collision[%0d]@%0d", d, cyc), coll[d], exp_c);
    exp_c = 1'b0;
    we_a  = 1'b0;
    re_a  = 1'b0;
    we_b  = 1'b0;
    re_b  = 1'b0;
  endtask

  task automatic drive(input logic wa, input logic ra, input logic [3:0] aa,
                       input logic [31:0] da, input logic [3:0] ba,
                       input logic wb, input logic rb, input logic [3:0] ab,
                       input logic [31:0] db, input logic [3:0] bb);
    exp_t e;
    we_a = wa; re_a = ra; addr_a = aa; wdata_a = da; be_a = ba;
    we_b = wb; re_b = rb; addr_b = ab; wdata_b = db; be_b = bb;
    // Instance d has latency 1+d; instance 0 is write-first, instance 1 read-first.
    for (int d = 0; d < 2; d++) begin
      if (ra) begin
        e.data = (wa && d == 0) ? merge(model[aa], da, ba) : model[aa];
        e.due  = cyc + 1 + d;
        sb[2*d].push_back(e);
      end
      if (rb) begin
        e.data = (wb && d == 0) ? merge(model[ab], db, bb) : model[ab];
        e.due  = cyc + 1 + d;
        sb[2*d+1].push_back(e);
      end
    end
    exp_c = (aa == ab) && (wa || wb) && (wa || ra) && (wb || rb);
    if (wb) model[ab] = merge(model[ab], db, bb);
    if (wa) model[aa] = merge(model[aa], da, ba);
  endtask

  task automatic reset_sb();
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      last[k] = '0;
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 4'(i), base + 32'h0101_0101 * i, 4'hf, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic readall();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), 0, 0, 0, 1, 4'(15 - i), 0, 0);
      step();
    end
    repeat (3) step();
  endtask

`ifdef DPRAM_CLEAR_EN
  task automatic clear_wait();
    for (int i = 0; i < 16; i++) begin
      if (i == 14) begin
        // Dropped while busy: no write to the already-cleared word 0, no rvalid, no collision.
        we_a = 1; addr_a = 0; wdata_a = '1; be_a = '1; re_b = 1; addr_b = 0;
      end
      step();
      for (int d = 0; d < 2; d++) chk($sformatf("init_busy[%0d] clr%0d", d, i), busy[d], i < 15);
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask
`endif

  initial begin
    tests = 0; fails = 0; cyc = 0; exp_c = 0;
    rst = 1;
    we_a = 0; re_a = 0; we_b = 0; re_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0; be_a = 0; be_b = 0;
    reset_sb();
    step();
    step();
`ifdef DPRAM_CLEAR_EN
    for (int d = 0; d < 2; d++) chk("init_busy_in_reset", busy[d], 1'b1);
    rst = 0;
    clear_wait();
    readall();
`else
    for (int d = 0; d < 2; d++) chk("init_busy_in_reset", busy[d], 1'b0);
    rst = 0;
    for (int d = 0; d < 2; d++) chk("init_busy_after", busy[d], 1'b0);
`endif
    fill(32'h1000_0000);
    readall();

    // Byte enables across two ports on separate cycles.
    drive(1, 0, 5, 32'hAABB_CCDD, 4'hf, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 5, 32'h1122_3344, 4'h5); step();
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0, 0); step();
    step(); step();

    // Same-cycle write-write conflict: A owns byte 0, B supplies byte 1.
    drive(1, 0, 9, 0, 4'hf, 0, 0, 0, 0, 0); step();
    drive(1, 0, 9, 32'h0000_00FF, 4'h1, 1, 0, 9, 32'h0000_EEEE, 4'h3); step();
    drive(0, 1, 9, 0, 0, 0, 0, 0, 0, 0); step();
    step(); step();

    // Read-during-write same port and cross port.
    drive(1, 0, 3, 32'h1, 4'hf, 0, 0, 0, 0, 0); step();
    drive(1, 1, 3, 32'h2, 4'hf, 0, 1, 3, 0, 0); step();
    step(); step();

    // Back-to-back reads on both ports.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 4'(i), 0, 0, 0, 1, 4'(i + 8), 0, 0);
      step();
    end
    step(); step(); step();

    // Write with no byte enables changes nothing.
    drive(1, 0, 4, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 4, 0, 0, 0, 0, 0, 0, 0); step();
    step(); step();

    for (int n = 0; n < 120; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
            $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
            $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    step(); step(); step();
    readall();

`ifdef DPRAM_CLEAR_EN
    fill(32'h5A00_0001);
    rst = 1;
    reset_sb();
    step();
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      for (int d = 0; d < 2; d++) chk("init_busy_pre_restart", busy[d], 1'b1);
    end
    rst = 1;
    reset_sb();
    step();
    rst = 0;
    clear_wait();
    readall();
`endif

    for (int k = 0; k < 4; k++) chk($sformatf("sb_drained[%0d]", k), sb[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
